ajw_pipe_addsub_unit: RTL and testbench
=======================================

AJW_PIPE_ADDSUB_UNIT -- requirements
Module: ajw_pipe_addsub_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter STAGES, default 4, giving the number of pipeline stages; WIDTH % STAGES == 0 and 1 <= STAGES <= WIDTH; CHUNK = WIDTH/STAGES.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clk_i  input  1  clock, sole clock, rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid_i  input  1  operation offered.
REQ-006 in_ready_o  output  1  operation accepted when in_valid_i && in_ready_o at the clock edge.
REQ-007 op_a_i, op_b_i  input  WIDTH  operands X and Y.
REQ-008 sub_i  input  1  1 = subtract mode, Y is inverted.
REQ-009 cin_i  input  1  carry-in to bit 0.
REQ-010 flush_i  input  1  discard all in-flight operations.
REQ-011 out_valid_o  output  1  result available.
REQ-012 out_ready_i  input  1  result consumed when out_valid_o && out_ready_i.
REQ-013 result_o  output  WIDTH  sum.
REQ-014 cout_o, overflow_o, zero_o, neg_o  output  1 each  carry-out, signed overflow, result==0, result[WIDTH-1].

Function
REQ-015 The block SHALL compute Y' = sub_i ? ~op_b_i : op_b_i and {cout, result} = op_a_i + Y' + cin_i, all unsigned at WIDTH+1 bits; subtraction A-B therefore requires cin_i=1.
REQ-016 overflow_o SHALL be (A[msb]==Y'[msb]) && (result[msb]!=A[msb]); zero_o and neg_o SHALL be derived from the full result.
REQ-017 Stage k (0..STAGES-1) SHALL add chunk k of A and Y' using the carry registered by stage k-1 (cin_i for k=0), and SHALL register its partial sum, carry, lower result chunks and the still-unadded upper operand chunks.
REQ-018 Latency SHALL be exactly STAGES cycles from the acceptance edge to out_valid_o high with out_ready_i held at 1; STAGES=1 gives a single registered adder.
REQ-019 Each stage SHALL hold a valid bit and advance when it is empty or its successor advances (the last stage's successor advances when out_ready_i=1); bubbles SHALL collapse.
REQ-020 in_ready_o SHALL be (!stage0_valid || stage0_advances) && !flush_i; throughput SHALL be one operation per cycle under no backpressure.
REQ-021 With out_ready_i low, out_valid_o, result_o and the flags SHALL hold stable until consumed; at most STAGES operations are in flight and none is lost or reordered.
REQ-022 flush_i=1 SHALL clear every stage valid bit at the next edge; no input is accepted in that cycle, and the results flushed are never presented.
REQ-023 Simultaneous input accept and output consume SHALL both occur in the same cycle.

Reset
REQ-024 While rst_ni=0, out_valid_o and all stage valid bits SHALL be 0 immediately (asynchronously), and in_ready_o SHALL be 0.
REQ-025 Reset SHALL clear result_o, cout_o, overflow_o, zero_o and neg_o to 0; reset mid-operation SHALL discard all in-flight operations.
REQ-026 in_ready_o SHALL be 1 from the first rising edge after rst_ni deasserts.

Structure
REQ-027 Package ajw_addsub_pkg SHALL hold the default WIDTH/STAGES constants and a typedef flags_t {cout, overflow, zero, neg}.
REQ-028 Sub-module ajw_addsub_chunk SHALL implement one CHUNK-bit adder with carry in/out and be instantiated STAGES times via generate.

Verification (WIDTH=32, STAGES=4, out_ready_i=1 unless stated)
REQ-029 add: A=0xFFFF_FFFF, B=1, cin=0 -> 4 cycles later result 0x0000_0000, cout 1, zero 1, overflow 0.
REQ-030 sub: A=0x8000_0000, B=1, cin=1 -> result 0x7FFF_FFFF, cout 1, overflow 1, neg 0.
REQ-031 8 back-to-back random ops -> 8 results on consecutive cycles starting at cycle 4, all matching the reference model, in order.
REQ-032 out_ready_i=0 for 10 cycles with continuous input -> exactly 4 accepted, in_ready_o low afterwards; release -> all 4 emerge in order, unchanged.
REQ-033 flush_i pulsed with 3 ops in flight -> no out_valid_o for those 3; the next op completes with latency 4.
REQ-034 rst_ni dropped mid-flight (asynchronously, between edges) -> out_valid_o 0 at once and all outputs 0; after release the unit accepts ops normally.

Source files
------------

// File: rtl/ajw_addsub_pkg.sv
// Shared constants and flag bundle for the pipelined add/subtract unit.
// The flag helper keeps the overflow/zero/neg definitions in one place.
`timescale 1ns/1ps
package ajw_addsub_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_STAGES = 4;

  typedef struct packed {
    logic cout;
    logic overflow;
    logic zero;
    logic neg;
  } flags_t;

  // Signed overflow: both addends share a sign that the sum does not.
  function automatic flags_t makeFlags(input logic cout, input logic aMsb,
                                       input logic yMsb, input logic sumMsb,
                                       input logic isZero);
    flags_t f;
    f.cout     = cout;
    f.overflow = (aMsb == yMsb) && (sumMsb != aMsb);
    f.zero     = isZero;
    f.neg      = sumMsb;
    return f;
  endfunction

endpackage

// File: rtl/ajw_addsub_chunk.sv
// One CHUNK-bit slice of the pipelined adder: plain ripple add with carry in/out.
`timescale 1ns/1ps
module ajw_addsub_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_c,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_c
);

  logic [CHUNK:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_c};
  assign o_sum  = w_full[CHUNK-1:0];
  assign o_c    = w_full[CHUNK];

endmodule

// File: rtl/ajw_pipe_addsub_unit.sv
// Pipelined WIDTH-bit adder/subtractor: stage k adds chunk k with the carry from
// stage k-1, under a valid/ready pipeline with collapsing bubbles and flush.
`timescale 1ns/1ps
module ajw_pipe_addsub_unit
  import ajw_addsub_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             sub_i,
  input  logic             cin_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             cout_o,
  output logic             overflow_o,
  output logic             zero_o,
  output logic             neg_o
);

  localparam int CHUNK = WIDTH / STAGES;

  logic [WIDTH-1:0]  r_a   [STAGES];
  logic [WIDTH-1:0]  r_y   [STAGES];
  logic [WIDTH-1:0]  r_sum [STAGES];
  logic [STAGES-1:0] r_c;
  logic [STAGES-1:0] r_v;
  flags_t            r_flags;
  logic              r_rstDone;

  logic [WIDTH-1:0]  w_srcA    [STAGES];
  logic [WIDTH-1:0]  w_srcY    [STAGES];
  logic [WIDTH-1:0]  w_srcSum  [STAGES];
  logic [WIDTH-1:0]  w_nextSum [STAGES];
  logic [STAGES-1:0] w_srcC;
  logic [STAGES-1:0] w_srcV;
  logic [STAGES-1:0] w_nextC;
  logic [STAGES-1:0] w_adv;
  logic [WIDTH-1:0]  w_yIn;
  logic              w_accept;
  flags_t            w_nextFlags;

  assign w_yIn      = sub_i ? ~op_b_i : op_b_i;
  // r_rstDone holds off acceptance until the first edge after reset release.
  assign in_ready_o = r_rstDone && w_adv[0] && !flush_i;
  assign w_accept   = in_valid_i && in_ready_o;

  always_comb begin
    w_adv = '0;
    w_adv[STAGES-1] = !r_v[STAGES-1] || out_ready_i;
    for (int k = STAGES - 2; k >= 0; k--) begin
      w_adv[k] = !r_v[k] || w_adv[k+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK-1:0] w_chunkSum;
    logic             w_chunkC;
    logic [WIDTH-1:0] w_merged;

    if (k == 0) begin : g_head
      assign w_srcA[k]   = op_a_i;
      assign w_srcY[k]   = w_yIn;
      assign w_srcSum[k] = '0;
      assign w_srcC[k]   = cin_i;
      assign w_srcV[k]   = w_accept;
    end else begin : g_tail
      assign w_srcA[k]   = r_a[k-1];
      assign w_srcY[k]   = r_y[k-1];
      assign w_srcSum[k] = r_sum[k-1];
      assign w_srcC[k]   = r_c[k-1];
      assign w_srcV[k]   = r_v[k-1];
    end

    ajw_addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
      .i_a   (w_srcA[k][k*CHUNK +: CHUNK]),
      .i_b   (w_srcY[k][k*CHUNK +: CHUNK]),
      .i_c   (w_srcC[k]),
      .o_sum (w_chunkSum),
      .o_c   (w_chunkC)
    );

    always_comb begin
      w_merged = w_srcSum[k];
      w_merged[k*CHUNK +: CHUNK] = w_chunkSum;
    end

    assign w_nextSum[k] = w_merged;
    assign w_nextC[k]   = w_chunkC;
  end

  // Flags come from the last stage's combinational sum so they register with it.
  assign w_nextFlags = makeFlags(w_nextC[STAGES-1], w_srcA[STAGES-1][WIDTH-1],
                                 w_srcY[STAGES-1][WIDTH-1], w_nextSum[STAGES-1][WIDTH-1],
                                 w_nextSum[STAGES-1] == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rstDone <= 1'b0;
      r_v       <= '0;
      r_c       <= '0;
      r_flags   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]   <= '0;
        r_y[k]   <= '0;
        r_sum[k] <= '0;
      end
    end else begin
      r_rstDone <= 1'b1;
      for (int k = 0; k < STAGES; k++) begin
        if (w_adv[k]) begin
          r_v[k] <= w_srcV[k];
          if (w_srcV[k]) begin
            r_a[k]   <= w_srcA[k];
            r_y[k]   <= w_srcY[k];
            r_sum[k] <= w_nextSum[k];
            r_c[k]   <= w_nextC[k];
          end
        end
      end
      if (w_adv[STAGES-1] && w_srcV[STAGES-1]) begin
        r_flags <= w_nextFlags;
      end
      if (flush_i) begin
        r_v <= '0;
      end
    end
  end

  assign out_valid_o = r_v[STAGES-1];
  assign result_o    = r_sum[STAGES-1];
  assign cout_o      = r_flags.cout;
  assign overflow_o  = r_flags.overflow;
  assign zero_o      = r_flags.zero;
  assign neg_o       = r_flags.neg;

endmodule

// File: tb/tb_ajw_pipe_addsub_unit.sv
// Self-checking bench for ajw_pipe_addsub_unit: vector table plus random ops,
// backpressure, flush and mid-flight reset, all scored through an expected-result queue.
`timescale 1ns/1ps
module tb_ajw_pipe_addsub_unit;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b1;
  logic              in_valid_i = 1'b0;
  logic              in_ready_o;
  logic [WIDTH-1:0]  op_a_i = '0;
  logic [WIDTH-1:0]  op_b_i = '0;
  logic              sub_i = 1'b0;
  logic              cin_i = 1'b0;
  logic              flush_i = 1'b0;
  logic              out_valid_o;
  logic              out_ready_i = 1'b1;
  logic [WIDTH-1:0]  result_o;
  logic              cout_o, overflow_o, zero_o, neg_o;
  logic [3:0]        flagsOut;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        cin;
    logic [31:0] expR;
    logic [3:0]  expF;
  } vec_t;

  typedef struct {
    logic [31:0] r;
    logic [3:0]  f;
    int          cyc;
  } sbItem_t;

  vec_t        vecs [10];
  sbItem_t     sb [$];
  int          numChecks = 0;
  int          numPass = 0;
  int          cycle = 0;
  bit          checkLatency = 1'b0;
  logic [31:0] curExpR = '0;
  logic [3:0]  curExpF = '0;

  ajw_pipe_addsub_unit #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .op_a_i      (op_a_i),
    .op_b_i      (op_b_i),
    .sub_i       (sub_i),
    .cin_i       (cin_i),
    .flush_i     (flush_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o),
    .cout_o      (cout_o),
    .overflow_o  (overflow_o),
    .zero_o      (zero_o),
    .neg_o       (neg_o)
  );

  assign flagsOut = {cout_o, overflow_o, zero_o, neg_o};

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    numChecks++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cycle);
    end else begin
      numPass++;
    end
  endtask

  // Flat reference: whole-width add, flags packed as {cout, overflow, zero, neg}.
  function automatic void refModel(input logic [31:0] a, input logic [31:0] b,
                                   input logic sub, input logic cin,
                                   output logic [31:0] r, output logic [3:0] f);
    logic [31:0] y;
    logic [32:0] s;
    y = sub ? ~b : b;
    s = {1'b0, a} + {1'b0, y} + {32'd0, cin};
    r = s[31:0];
    f = {s[32], (a[31] == y[31]) && (s[31] != a[31]), s[31:0] == 32'd0, s[31]};
  endfunction

  // Scoreboard: push on accept, pop and compare on consume, drop on flush/reset.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      sb.delete();
    end else begin
      if (out_valid_o && out_ready_i) begin
        if (sb.size() == 0) begin
          checkOutput("unexpectedOut", 64'd1, 64'd0);
        end else begin
          sbItem_t item;
          item = sb.pop_front();
          checkOutput("result", result_o, item.r);
          checkOutput("flags", flagsOut, item.f);
          if (checkLatency) checkOutput("latency", cycle - item.cyc, STAGES);
        end
      end
      if (flush_i) sb.delete();
      if (in_valid_i && in_ready_o) sb.push_back('{curExpR, curExpF, cycle});
    end
  end

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sub,
                               input logic cin, input logic [31:0] er, input logic [3:0] ef);
    bit acc;
    acc = 1'b0;
    op_a_i = a; op_b_i = b; sub_i = sub; cin_i = cin;
    curExpR = er; curExpF = ef; in_valid_i = 1'b1;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk_i);
      acc = in_ready_o;
      @(posedge clk_i); #1;
    end
    if (!acc) checkOutput("acceptTimeout", 64'd0, 64'd1);
  endtask

  task automatic applyRandom();
    logic [31:0] a, b, r;
    logic [3:0]  f;
    logic        sub, cin;
    a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom);
    refModel(a, b, sub, cin, r, f);
    applyStimulus(a, b, sub, cin, r, f);
  endtask

  task automatic waitDrain(input int maxCycles);
    bit done;
    done = 1'b0;
    for (int t = 0; t < maxCycles && !done; t++) begin
      @(negedge clk_i);
      if (sb.size() == 0 && !out_valid_o) done = 1'b1;
    end
    checkOutput("drained", done, 1'b1);
    @(posedge clk_i); #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc;
    int outCnt;

    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 4'b1010};
    vecs[1] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 4'b1100};
    vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 4'b0101};
    vecs[3] = '{32'h0000_0005, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0000, 4'b1010};
    vecs[4] = '{32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1, 32'hFFFF_FFFE, 4'b0001};
    vecs[5] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h0001_0001, 4'b0000};
    vecs[6] = '{32'h00FF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h0100_0000, 4'b0000};
    vecs[7] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'hFFFF_FFFF, 4'b0001};
    vecs[8] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 4'b0000};
    vecs[9] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 4'b1110};

    // Reset asserted between edges: outputs must clear before any clock.
    #2 rst_ni = 1'b0;
    #1;
    checkOutput("rstOutValid", out_valid_o, 1'b0);
    checkOutput("rstInReady", in_ready_o, 1'b0);
    checkOutput("rstResult", result_o, 32'd0);
    checkOutput("rstFlags", flagsOut, 4'd0);
    repeat (2) @(posedge clk_i);
    #3 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    checkOutput("inReadyAfterRst", in_ready_o, 1'b1);

    $display("[TB] vector table, back-to-back");
    checkLatency = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, vecs[i].expR, vecs[i].expF);
    end
    in_valid_i = 1'b0;
    waitDrain(40);

    $display("[TB] random back-to-back ops");
    for (int i = 0; i < 8; i++) applyRandom();
    in_valid_i = 1'b0;
    waitDrain(40);

    $display("[TB] backpressure");
    checkLatency = 1'b0;
    out_ready_i = 1'b0;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      logic [31:0] a, b;
      logic        sub, cin;
      a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom);
      op_a_i = a; op_b_i = b; sub_i = sub; cin_i = cin;
      refModel(a, b, sub, cin, curExpR, curExpF);
      in_valid_i = 1'b1;
      @(negedge clk_i);
      if (in_ready_o) acc++;
      @(posedge clk_i); #1;
    end
    in_valid_i = 1'b0;
    checkOutput("bpAccepted", acc, 4);
    @(negedge clk_i);
    checkOutput("bpInReadyLow", in_ready_o, 1'b0);
    checkOutput("bpOutValidHeld", out_valid_o, 1'b1);
    @(posedge clk_i); #1;
    out_ready_i = 1'b1;
    waitDrain(40);

    $display("[TB] flush with three in flight");
    for (int i = 0; i < 3; i++) applyRandom();
    flush_i = 1'b1;
    in_valid_i = 1'b1;
    @(negedge clk_i);
    checkOutput("flushInReady", in_ready_o, 1'b0);
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    outCnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      if (out_valid_o) outCnt++;
    end
    checkOutput("flushNoOutput", outCnt, 0);
    @(posedge clk_i); #1;
    checkLatency = 1'b1;
    applyRandom();
    in_valid_i = 1'b0;
    waitDrain(40);

    $display("[TB] reset mid-flight");
    checkLatency = 1'b0;
    out_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(32'h10 + i, 32'h20, 1'b0, 1'b0, 32'h30 + i, 4'b0000);
    end
    in_valid_i = 1'b0;
    @(negedge clk_i);
    checkOutput("preResetValid", out_valid_o, 1'b1);
    @(posedge clk_i);
    #3 rst_ni = 1'b0;
    #1;
    checkOutput("midRstOutValid", out_valid_o, 1'b0);
    checkOutput("midRstInReady", in_ready_o, 1'b0);
    checkOutput("midRstResult", result_o, 32'd0);
    checkOutput("midRstFlags", flagsOut, 4'd0);
    repeat (2) @(posedge clk_i);
    #3 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    checkOutput("inReadyAfterMidRst", in_ready_o, 1'b1);
    out_ready_i = 1'b1;
    checkLatency = 1'b1;
    applyStimulus(vecs[1].a, vecs[1].b, vecs[1].sub, vecs[1].cin, vecs[1].expR, vecs[1].expF);
    applyStimulus(vecs[9].a, vecs[9].b, vecs[9].sub, vecs[9].cin, vecs[9].expR, vecs[9].expF);
    in_valid_i = 1'b0;
    waitDrain(40);

    $display("%0d/%0d checks passed", numPass, numChecks);
    $finish;
  end

endmodule
